// File: rtl/led_fade_scheduler.sv
// Per-channel brightness ramp scheduler: each level walks one step toward its target on a
// shared prescaled tick, with a single update slot rotated round-robin across channels.
module led_fade_scheduler #(
  parameter int NCHAN   = 4,
  parameter int LEVEL_W = 8,
  parameter int RATE_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic [7:0]                 tick_div,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [$clog2(NCHAN)-1:0]   cmd_chan,
  input  logic [LEVEL_W-1:0]         cmd_target,
  input  logic [RATE_W-1:0]          cmd_rate,
  output logic [NCHAN*LEVEL_W-1:0]   level,
  output logic [NCHAN-1:0]           busy,
  output logic [NCHAN-1:0]           done
);

  localparam int CW = $clog2(NCHAN);

  logic [15:0]        presc_q, presc_d;
  logic [CW-1:0]      ptr_q, ptr_d;
  logic [NCHAN-1:0]   pend_q, pend_d;
  logic [NCHAN-1:0]   busy_q, busy_d;
  logic [NCHAN-1:0]   done_q, done_d;
  logic [LEVEL_W-1:0] level_q [NCHAN];
  logic [LEVEL_W-1:0] level_d [NCHAN];
  logic [LEVEL_W-1:0] target_q [NCHAN];
  logic [LEVEL_W-1:0] target_d [NCHAN];
  logic [RATE_W-1:0]  rate_q [NCHAN];
  logic [RATE_W-1:0]  rate_d [NCHAN];
  logic [RATE_W-1:0]  rcnt_q [NCHAN];
  logic [RATE_W-1:0]  rcnt_d [NCHAN];
  logic               rdy_q;
  logic               live_q;
  logic               gtick;
  logic               accept;

  // A count already past a lowered compare value runs on to 16'hFFFF and wraps without a tick.
  assign gtick  = ena && (presc_q == {tick_div, 8'hFF});
  assign accept = cmd_valid && rdy_q;

  always_comb begin
    presc_d = presc_q;
    ptr_d   = ptr_q;
    if (ena) begin
      presc_d = gtick ? 16'd0 : presc_q + 16'd1;
      ptr_d   = (ptr_q == CW'(NCHAN - 1)) ? '0 : ptr_q + CW'(1);
    end
  end

  always_comb begin
    for (int c = 0; c < NCHAN; c++) begin
      level_d[c]  = level_q[c];
      target_d[c] = target_q[c];
      rate_d[c]   = rate_q[c];
      rcnt_d[c]   = rcnt_q[c];
      pend_d[c]   = pend_q[c];
      done_d[c]   = 1'b0;
      if (ena) begin
        if (pend_q[c] && (ptr_q == CW'(c))) begin
          pend_d[c] = 1'b0;
          if (rcnt_q[c] != '0) begin
            rcnt_d[c] = rcnt_q[c] - RATE_W'(1);
          end else begin
            rcnt_d[c] = rate_q[c];
            if (level_q[c] < target_q[c]) begin
              level_d[c] = level_q[c] + LEVEL_W'(1);
              done_d[c]  = (level_d[c] == target_q[c]);
            end else if (level_q[c] > target_q[c]) begin
              level_d[c] = level_q[c] - LEVEL_W'(1);
              done_d[c]  = (level_d[c] == target_q[c]);
            end
          end
        end
        // A tick landing on a service cycle re-arms the bit so that tick is not lost.
        if (gtick) pend_d[c] = 1'b1;
      end
      // A command overrides any service of the same channel in this cycle.
      if (accept && (cmd_chan == CW'(c))) begin
        target_d[c] = cmd_target;
        rate_d[c]   = cmd_rate;
        rcnt_d[c]   = cmd_rate;
        pend_d[c]   = 1'b0;
        level_d[c]  = level_q[c];
        done_d[c]   = 1'b0;
      end
      busy_d[c] = (level_d[c] != target_d[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      ptr_q    <= '0;
      pend_q   <= '0;
      busy_q   <= '0;
      done_q   <= '0;
      rdy_q    <= 1'b0;
      live_q   <= 1'b0;
      level_q  <= '{default: '0};
      target_q <= '{default: '0};
      rate_q   <= '{default: '0};
      rcnt_q   <= '{default: '0};
    end else begin
      presc_q  <= presc_d;
      ptr_q    <= ptr_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      live_q   <= 1'b1;
      // Ready is held off for one full cycle after reset release.
      rdy_q    <= ena && live_q;
      level_q  <= level_d;
      target_q <= target_d;
      rate_q   <= rate_d;
      rcnt_q   <= rcnt_d;
    end
  end

  for (genvar g = 0; g < NCHAN; g++) begin : g_lvl
    assign level[g*LEVEL_W +: LEVEL_W] = level_q[g];
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_ready = rdy_q;

endmodule

// File: tb/tb_led_fade_scheduler.sv
// Scoreboard bench for led_fade_scheduler: expected steps, step spacing and done pulses
// are queued per channel by the stimulus and consumed by an independent negedge monitor.
module tb_led_fade_scheduler;

  localparam int NCHAN = 4;
  localparam int LW    = 8;
  localparam int RW    = 4;
  localparam int CW    = 2;

  typedef struct {
    logic [95:0] name;
    int          act;
    int          exp;
  } chk_t;

  typedef struct {
    int lvl;
    int gap;
  } step_t;

  logic                  clk;
  logic                  rst_n;
  logic                  ena;
  logic [7:0]            tick_div;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [CW-1:0]         cmd_chan;
  logic [LW-1:0]         cmd_target;
  logic [RW-1:0]         cmd_rate;
  logic [NCHAN*LW-1:0]   level_bus;
  logic [NCHAN-1:0]      busy;
  logic [NCHAN-1:0]      done;

  chk_t  chk_q [$];
  step_t exp_q [NCHAN][$];
  int    expd_q [NCHAN][$];

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    last_lvl [NCHAN];
  int    last_cyc [NCHAN];
  chk_t  mk;
  step_t ms;
  int    mlv;
  int    md;

  led_fade_scheduler #(.NCHAN(NCHAN), .LEVEL_W(LW), .RATE_W(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .tick_div   (tick_div),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_chan   (cmd_chan),
    .cmd_target (cmd_target),
    .cmd_rate   (cmd_rate),
    .level      (level_bus),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lvl(input int c);
    return int'(level_bus[c*LW +: LW]);
  endfunction

  task automatic push_chk(input logic [95:0] name, input int act, input int exp);
    chk_t k;
    k.name = name;
    k.act  = act;
    k.exp  = exp;
    chk_q.push_back(k);
  endtask

  // gap = required cycles since this channel's previous step; 0 leaves spacing unchecked
  task automatic push_step(input int c, input int l, input int g);
    step_t s;
    s.lvl = l;
    s.gap = g;
    exp_q[c].push_back(s);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic cmd(input int c, input int t, input int r);
    int k;
    k = 0;
    cmd_valid  = 1'b1;
    cmd_chan   = CW'(c);
    cmd_target = LW'(t);
    cmd_rate   = RW'(r);
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    push_chk("cmd_ready", int'(cmd_ready), 1);
    @(negedge clk);
  endtask

  task automatic wait_level(input int c, input int v, input int budget);
    int k;
    k = 0;
    while (lvl(c) != v && k < budget) begin
      @(negedge clk);
      k++;
    end
    push_chk("wait_level", lvl(c), v);
  endtask

  always @(negedge clk) begin
    cyc = cyc + 1;
    while (chk_q.size() > 0) begin
      mk = chk_q.pop_front();
      n_tests++;
      if (mk.act != mk.exp) begin
        n_fail++;
        $display("FAIL %0s: got %0d expected %0d", mk.name, mk.act, mk.exp);
      end
    end
    if (!rst_n) begin
      for (int c = 0; c < NCHAN; c++) begin
        last_lvl[c] = 0;
        last_cyc[c] = cyc;
      end
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        mlv = lvl(c);
        if (mlv != last_lvl[c]) begin
          n_tests++;
          if (exp_q[c].size() == 0) begin
            n_fail++;
            $display("FAIL step_ch%0d: got level %0d expected no step", c, mlv);
          end else begin
            ms = exp_q[c].pop_front();
            if (mlv != ms.lvl) begin
              n_fail++;
              $display("FAIL step_ch%0d: got level %0d expected %0d", c, mlv, ms.lvl);
            end else if (ms.gap != 0 && (cyc - last_cyc[c]) != ms.gap) begin
              n_fail++;
              $display("FAIL gap_ch%0d: got %0d cycles expected %0d", c, cyc - last_cyc[c], ms.gap);
            end
          end
          last_lvl[c] = mlv;
          last_cyc[c] = cyc;
        end
        if (done[c]) begin
          n_tests++;
          if (expd_q[c].size() == 0) begin
            n_fail++;
            $display("FAIL done_ch%0d: got pulse at level %0d expected none", c, mlv);
          end else begin
            md = expd_q[c].pop_front();
            if (mlv != md) begin
              n_fail++;
              $display("FAIL done_ch%0d: got pulse at level %0d expected %0d", c, mlv, md);
            end
          end
        end
      end
    end
  end

  initial begin
    #700000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    ena        = 1'b1;
    tick_div   = 8'd0;
    cmd_valid  = 1'b0;
    cmd_chan   = '0;
    cmd_target = '0;
    cmd_rate   = '0;
    repeat (3) @(negedge clk);
    push_chk("rst_level", int'(level_bus), 0);
    push_chk("rst_busy", int'(busy), 0);
    push_chk("rst_done", int'(done), 0);
    push_chk("rst_ready", int'(cmd_ready), 0);
    rst_n = 1'b1;
    push_chk("rdy_rel0", int'(cmd_ready), 0);
    @(negedge clk);
    push_chk("rdy_rel1", int'(cmd_ready), 0);
    @(negedge clk);
    push_chk("rdy_rel2", int'(cmd_ready), 1);

    // basic up-ramp on channel 0
    push_step(0, 1, 0); push_step(0, 2, 256); push_step(0, 3, 256);
    expd_q[0].push_back(3);
    cmd(0, 3, 0);
    cmd_valid = 1'b0;
    push_chk("busy0_set", int'(busy[0]), 1);
    wait_level(0, 3, 1500);
    push_chk("busy0_clr", int'(busy[0]), 0);

    // channel 1 up to 10, then down to 7 stepping every third tick
    push_step(1, 1, 0);
    for (int v = 2; v <= 10; v++) push_step(1, v, 256);
    expd_q[1].push_back(10);
    cmd(1, 10, 0);
    cmd_valid = 1'b0;
    wait_level(1, 10, 3500);
    push_step(1, 9, 768); push_step(1, 8, 768); push_step(1, 7, 768);
    expd_q[1].push_back(7);
    cmd(1, 7, 2);
    cmd_valid = 1'b0;
    push_chk("busy1_down", int'(busy[1]), 1);
    wait_level(1, 7, 3000);

    // round-robin: all channels to 5 from levels 3,7,0,0
    push_step(0, 4, 0); push_step(0, 5, 256);
    push_step(1, 6, 0); push_step(1, 5, 256);
    for (int c = 2; c < NCHAN; c++) begin
      push_step(c, 1, 0);
      for (int v = 2; v <= 5; v++) push_step(c, v, 256);
    end
    for (int c = 0; c < NCHAN; c++) expd_q[c].push_back(5);
    cmd(0, 5, 0); cmd(1, 5, 0); cmd(2, 5, 0); cmd(3, 5, 0);
    cmd_valid = 1'b0;
    wait_level(2, 5, 1700);
    wait_level(3, 5, 10);
    @(negedge clk);
    push_chk("rr_skew", last_cyc[3] - last_cyc[2], 1);
    push_chk("rr_lvl0", lvl(0), 5);
    push_chk("rr_lvl1", lvl(1), 5);

    // command equal to current level: no done, not busy
    cmd(0, 5, 0);
    cmd_valid = 1'b0;
    push_chk("same_busy", int'(busy[0]), 0);

    // collision: reverse channel 2 in the very cycle its service would step 8 -> 9
    push_step(2, 6, 0); push_step(2, 7, 256); push_step(2, 8, 256);
    push_step(2, 7, 512);
    for (int v = 6; v >= 0; v--) push_step(2, v, 256);
    expd_q[2].push_back(0);
    cmd(2, 20, 0);
    cmd_valid = 1'b0;
    wait_level(2, 8, 1500);
    repeat (255) @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_chan   = 2'd2;
    cmd_target = 8'd0;
    cmd_rate   = 4'd0;
    push_chk("coll_ready", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    push_chk("coll_hold", lvl(2), 8);
    push_chk("coll_busy", int'(busy[2]), 1);
    wait_level(2, 0, 2800);

    // enable freeze for 1000 cycles in the middle of a channel 3 ramp
    push_step(3, 6, 0); push_step(3, 7, 256); push_step(3, 8, 1256);
    push_step(3, 9, 256); push_step(3, 10, 256);
    expd_q[3].push_back(10);
    cmd(3, 10, 0);
    cmd_valid = 1'b0;
    wait_level(3, 7, 1500);
    repeat (100) @(negedge clk);
    ena = 1'b0;
    repeat (500) @(negedge clk);
    push_chk("frz_ready", int'(cmd_ready), 0);
    push_chk("frz_level", lvl(3), 7);
    repeat (500) @(negedge clk);
    ena = 1'b1;
    @(negedge clk);
    push_chk("frz_resume", int'(cmd_ready), 1);
    wait_level(3, 10, 2000);

    // asynchronous reset in the middle of a channel 0 ramp
    push_step(0, 6, 0); push_step(0, 7, 256);
    cmd(0, 100, 0);
    cmd_valid = 1'b0;
    wait_level(0, 7, 1500);
    @(posedge clk);
    #3;
    rst_n    = 1'b0;
    tick_div = 8'd16;
    #1;
    push_chk("arst_level", int'(level_bus), 0);
    push_chk("arst_busy", int'(busy), 0);
    push_chk("arst_done", int'(done), 0);
    push_chk("arst_ready", int'(cmd_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_chk("arst_rel0", int'(cmd_ready), 0);
    @(negedge clk);
    push_chk("arst_rel1", int'(cmd_ready), 0);
    @(negedge clk);
    push_chk("arst_rel2", int'(cmd_ready), 1);

    // tick_div=16: steps 4352 cycles apart
    push_step(1, 1, 0); push_step(1, 2, 4352); push_step(1, 3, 4352);
    expd_q[1].push_back(3);
    cmd(1, 3, 0);
    cmd_valid = 1'b0;
    wait_level(1, 3, 14000);

    repeat (4) @(negedge clk);
    for (int c = 0; c < NCHAN; c++) begin
      push_chk("drain_step", exp_q[c].size(), 0);
      push_chk("drain_done", expd_q[c].size(), 0);
    end
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_fade_scheduler.md
# led_fade_scheduler

Multi-channel fade scheduler that sequences brightness ramps for the exponential LED PWM datapath. It holds a per-channel target level and step rate, and moves each channel's linear level one step toward its target on a shared, programmable time base. A single time-shared update slot is rotated round-robin across channels. Each `level` output drives the exponential mapping and PWM channel of its lane. It sits between the user input pins / command source and the PWM channels in the top-level design.

## Interface
- `NCHAN`, 4: number of channels; legal range 2..16.
- `LEVEL_W`, 8: width of level and target values.
- `RATE_W`, 4: width of per-channel step-rate field.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  design enable; 0 freezes all state.
- `tick_div`  in  8  time-base divider; global tick period = (tick_div+1)*256 clocks.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when `cmd_valid` and `cmd_ready` are both high.
- `cmd_chan`  in  clog2(NCHAN)  target channel index.
- `cmd_target`  in  LEVEL_W  new target level.
- `cmd_rate`  in  RATE_W  channel steps once every (cmd_rate+1) global ticks.
- `level`  out  NCHAN*LEVEL_W  current level per channel; channel c occupies bits [c*LEVEL_W +: LEVEL_W].
- `busy`  out  NCHAN  bit c = (level[c] != target[c]).
- `done`  out  NCHAN  one-cycle pulse when channel c reaches its target by stepping.

## Operation
- **Prescaler:** 16-bit up-counter. When it equals {tick_div, 8'hFF}:
  - it wraps to 0;
  - `gtick` asserts for that cycle.
  - If `tick_div` is changed so that the count is already above the new compare value, the counter wraps naturally at 16'hFFFF, with no tick.
- **Pending bits:** `gtick` sets all bits in `pending[NCHAN-1:0]`; they are visible the next cycle.
- **Service pointer:** `ptr` increments by 1 every enabled cycle and wraps from NCHAN-1 to 0. Channel c is serviced in a cycle where ptr==c and pending[c]==1. Service:
  - clears pending[c];
  - if rcnt[c]!=0, decrements rcnt[c] and the level is unchanged;
  - else reloads rcnt[c]=rate[c] and steps level[c] by +1 if level<target, or -1 if level>target. There is no step if they are equal.
- Level arithmetic never wraps. Steps are only ever toward the target, so saturation at 0 and at 2^LEVEL_W-1 is inherent.
- `done[c]` pulses in the cycle after a step that makes level[c]==target[c].
- **Commands:** `cmd_ready` = ena, registered (0 during reset and for the first cycle after reset release). On accept:
  - target[cmd_chan] ← cmd_target;
  - rate[cmd_chan] ← cmd_rate;
  - rcnt[cmd_chan] ← cmd_rate;
  - pending[cmd_chan] is cleared.
  - Level is unchanged.
  - A command with target equal to the current level produces no `done` pulse.
- **Simultaneous events:**
  - A command accept to channel c in the same cycle c would be serviced: the command wins and no step occurs.
  - `gtick` in the same cycle as a service of c: pending[c] stays set, so the new tick is not lost.
  - A command to c on a `gtick` cycle: pending[c] ends cleared.
- **ena=0:** prescaler, ptr, pending, rcnt and levels all hold. `done` is forced to 0 and `cmd_ready` drops to 0 the next cycle.
- **Reset mid-ramp:** all state is cleared immediately (asynchronous); the ramp is abandoned and levels return to 0.

## Timing
- Reset values:
  - level = 0, target = 0, rate = 0, rcnt = 0;
  - pending = 0, ptr = 0, prescaler = 0;
  - busy = 0, done = 0, cmd_ready = 0.
- All outputs are registered. `busy` reflects target/level registers and changes the cycle after a command accept or a step.
- Tick to step latency: 1 to NCHAN cycles after the `gtick` cycle, determined by ptr position. The minimum tick period of 256 cycles is ≥ NCHAN, so every pending bit is serviced before the next tick.
- Step interval per channel = (rate+1)*(tick_div+1)*256 clocks, ±(NCHAN-1) cycles of service jitter.
- Command accept to target visible: 1 cycle.

## Test plan
- **Basic ramp:**
  - Stimulus: reset, tick_div=0, command chan0 target=3 rate=0.
  - Required: level0 steps 0→1→2→3 at ~256-cycle spacing; busy0 falls when level0 hits 3; exactly one `done[0]` pulse; other channels stay at 0.
- **Rate and down-ramp:**
  - Stimulus: chan1 at level 10, command target=7 rate=2.
  - Required: steps 10→9→8→7, one step every 3 ticks (~768 cycles); `done[1]` pulses once.
- **Round-robin fairness:**
  - Stimulus: all NCHAN channels commanded target=5 rate=0 in consecutive cycles.
  - Required: every channel steps within NCHAN cycles of each tick; all reach 5 by the 5th tick.
- **Collision:**
  - Stimulus: a command to chan2 in the exact cycle chan2 is serviced, with target reversed from 20 to 0.
  - Required: no step that cycle; the channel then ramps down from its current level; no lost or double step.
- **Enable freeze:**
  - Stimulus: drop ena for 1000 cycles mid-ramp.
  - Required: levels, prescaler and ptr hold; `cmd_ready` = 0; the ramp resumes with the same remaining interval after ena returns.
- **Async reset mid-ramp:**
  - Stimulus: assert rst_n low between clock edges while levels are nonzero.
  - Required: all outputs 0 immediately; `cmd_ready` stays 0 until the 2nd clock edge after release; tick_div=16 then gives a 4352-cycle tick period.
